// File: rtl/cnn_wr_packer.sv
// cnn_wr_packer: packs the CNN result byte stream into 32-byte lines and writes them out.
// Define CNN_WR_PACKER_DBL_BUF_EN for two ping-pong line buffers; default is one buffer.
module cnn_wr_packer #(
    parameter int ADDR_WIDTH        = 19,
    parameter int WORD_WIDTH        = 8,
    parameter int NUM_WORDS_IN_LINE = 32,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic [ADDR_WIDTH-1:0]                     base_addr,
    input  logic [CNT_WIDTH-1:0]                      total_cnt,
    input  logic                                      act_valid,
    input  logic [WORD_WIDTH-1:0]                     act_data,
    output logic                                      act_ready,
    output logic                                      mem_req,
    output logic [ADDR_WIDTH-1:0]                     mem_start_addr,
    output logic [$clog2(NUM_WORDS_IN_LINE):0]        mem_size_bytes,
    output logic [NUM_WORDS_IN_LINE*WORD_WIDTH-1:0]   mem_data,
    input  logic                                      mem_ack,
    output logic                                      busy,
    output logic                                      done
);

    localparam int LB = NUM_WORDS_IN_LINE;
    localparam int PW = $clog2(LB);
    localparam int SW = PW + 1;
    localparam int DW = LB * WORD_WIDTH;

    typedef enum logic {
        W_IDLE,
        W_REQ
    } wstate_e;

    logic                  r_busy;
    logic                  r_done;
    logic [CNT_WIDTH-1:0]  r_total;
    logic [CNT_WIDTH-1:0]  r_rx_cnt;
    logic [PW-1:0]         r_fill_ptr;
    logic [ADDR_WIDTH-1:0] r_line_addr;
    logic                  r_fsel;
    logic                  r_wsel;
    logic [DW-1:0]         r_buf  [2];
    logic [SW-1:0]         r_size [2];
    logic [ADDR_WIDTH-1:0] r_addr [2];
    logic [1:0]            r_full;
    logic [1:0]            r_last;
    wstate_e               r_wstate;
    wstate_e               w_wstate_nxt;

    logic w_act_ready;
    logic w_accept;
    logic w_last_byte;
    logic w_close;
    logic w_retire;
    logic w_fnext;
    logic w_wnext;
    logic w_more;
    logic w_mem_req;

`ifdef CNN_WR_PACKER_DBL_BUF_EN
    assign w_fnext = ~r_fsel;
    assign w_wnext = ~r_wsel;
`else
    assign w_fnext = r_fsel;
    assign w_wnext = r_wsel;
`endif

    assign w_act_ready = r_busy && !r_full[r_fsel] && (r_rx_cnt != r_total);
    assign w_accept    = act_valid && w_act_ready;
    assign w_last_byte = (r_rx_cnt + CNT_WIDTH'(1)) == r_total;
    assign w_close     = w_accept &&
                         ((r_fill_ptr == PW'(LB - 1)) || w_last_byte);
    assign w_retire    = (r_wstate == W_REQ) && mem_ack;
    // another line is ready to follow the one being retired
    assign w_more      = (w_wnext != r_wsel) &&
                         (r_full[w_wnext] || (w_close && (r_fsel == w_wnext)));

    // write-side state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    // write-side next state: request as soon as a line closes
    always_comb begin
        w_wstate_nxt = r_wstate;
        unique case (r_wstate)
            W_IDLE: begin
                if (r_full[r_wsel] || (w_close && (r_fsel == r_wsel))) begin
                    w_wstate_nxt = W_REQ;
                end
            end
            W_REQ: begin
                if (mem_ack && !w_more) begin
                    w_wstate_nxt = W_IDLE;
                end
            end
        endcase
    end

    // write-side outputs
    always_comb begin
        w_mem_req = (r_wstate == W_REQ);
    end

    // job control, line filling and line retirement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_total     <= '0;
            r_rx_cnt    <= '0;
            r_fill_ptr  <= '0;
            r_line_addr <= '0;
            r_fsel      <= 1'b0;
            r_wsel      <= 1'b0;
            r_full      <= '0;
            r_last      <= '0;
            for (int i = 0; i < 2; i++) begin
                r_buf[i]  <= '0;
                r_size[i] <= '0;
                r_addr[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (start && !r_busy) begin
                r_busy      <= 1'b1;
                r_total     <= total_cnt;
                r_rx_cnt    <= '0;
                r_fill_ptr  <= '0;
                r_line_addr <= base_addr;
                r_fsel      <= 1'b0;
                r_wsel      <= 1'b0;
            end
            if (w_accept) begin
                r_buf[r_fsel][r_fill_ptr*WORD_WIDTH +: WORD_WIDTH] <= act_data;
                r_rx_cnt   <= r_rx_cnt + CNT_WIDTH'(1);
                r_fill_ptr <= r_fill_ptr + PW'(1);
            end
            if (w_close) begin
                r_full[r_fsel] <= 1'b1;
                r_last[r_fsel] <= w_last_byte;
                r_size[r_fsel] <= SW'(r_fill_ptr) + SW'(1);
                r_addr[r_fsel] <= r_line_addr;
                r_line_addr    <= r_line_addr + ADDR_WIDTH'(LB);
                r_fill_ptr     <= '0;
                r_fsel         <= w_fnext;
            end
            // retired buffers are zeroed so partial lines pad with 0
            if (w_retire) begin
                r_full[r_wsel] <= 1'b0;
                r_buf[r_wsel]  <= '0;
                r_wsel         <= w_wnext;
                if (r_last[r_wsel]) begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
            end
        end
    end

    assign act_ready      = w_act_ready;
    assign mem_req        = w_mem_req;
    assign mem_start_addr = r_addr[r_wsel];
    assign mem_size_bytes = r_size[r_wsel];
    assign mem_data       = r_buf[r_wsel];
    assign busy           = r_busy;
    assign done           = r_done;

endmodule
